csa_select: RTL

CSA_SELECT -- requirements
Module: csa_select

---
 rtl/csa_pkg.sv | 15 +
 rtl/seg_select.sv | 33 +++
 rtl/csa_select.sv | 124 ++++++++++++
 3 files changed

// File: rtl/csa_pkg.sv
// Shared definitions for the carry-select result selector.
//   DefWidth / DefNseg : default segment width and segment count
//   state_e            : sequencing states of csa_select
package csa_pkg;

    localparam int unsigned DefWidth = 8;
    localparam int unsigned DefNseg  = 4;

    typedef enum logic [1:0] {
        StIdle,
        StResolve,
        StDone
    } state_e;

endpackage

// File: rtl/seg_select.sv
// One carry-select segment: picks the candidate sum and carry-out that match
// the incoming carry and flags an impossible candidate pair.
//   carry       : carry into this segment
//   s1_seg      : candidate sum assuming carry-in 0
//   s2_seg      : candidate sum assuming carry-in 1
//   c_out1_bit  : candidate carry-out assuming carry-in 0
//   c_out2_bit  : candidate carry-out assuming carry-in 1
//   sum_seg     : selected sum
//   carry_next  : selected carry-out
//   err_bit     : carry-out with carry-in 0 set but with carry-in 1 clear
module seg_select
    import csa_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth
) (
    input  logic             carry,
    input  logic [WIDTH-1:0] s1_seg,
    input  logic [WIDTH-1:0] s2_seg,
    input  logic             c_out1_bit,
    input  logic             c_out2_bit,
    output logic [WIDTH-1:0] sum_seg,
    output logic             carry_next,
    output logic             err_bit
);

    always_comb begin
        sum_seg    = carry ? s2_seg : s1_seg;
        carry_next = carry ? c_out2_bit : c_out1_bit;
        // Adding one more can never remove a carry-out; flag it independent of carry.
        err_bit    = c_out1_bit & ~c_out2_bit;
    end

endmodule

// File: rtl/csa_select.sv
// Sequential carry-select resolver. Accepts a bundle of per-segment candidate
// sums/carries, then walks the segments LSB first, one per cycle, selecting
// each by the running carry through a single shared seg_select.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : candidate bundle handshake (ready only in idle)
//   c_in                 : carry into segment 0
//   s1, s2               : candidate sums for carry-in 0 / 1, segment k at [k*WIDTH +: WIDTH]
//   c_out1, c_out2       : candidate carry-outs for carry-in 0 / 1
//   out_valid / out_ready: result handshake
//   sum, c_out, err      : selected sum, final carry, inconsistent-candidate flag
module csa_select
    import csa_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned NSEG  = DefNseg
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 c_in,
    input  logic [NSEG*WIDTH-1:0] s1,
    input  logic [NSEG*WIDTH-1:0] s2,
    input  logic [NSEG-1:0]      c_out1,
    input  logic [NSEG-1:0]      c_out2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NSEG*WIDTH-1:0] sum,
    output logic                 c_out,
    output logic                 err
);

    localparam int unsigned     CntW    = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam logic [CntW-1:0] LastSeg = CntW'(NSEG - 1);

    state_e state_q, state_d;

    logic [NSEG-1:0][WIDTH-1:0] s1_q, s2_q, sum_q;
    logic [NSEG-1:0]            c_out1_q, c_out2_q;
    logic [CntW-1:0]            cnt_q;
    logic                       carry_q;
    logic                       err_q;
    logic                       accept;

    logic [WIDTH-1:0] seg_sum;
    logic             seg_carry;
    logic             seg_err;

    assign accept = in_valid & in_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (in_valid)          state_d = StResolve;
            StResolve: if (cnt_q == LastSeg)  state_d = StDone;
            StDone:    if (out_ready)         state_d = StIdle;
            default:                          state_d = StIdle;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
    end

    seg_select #(
        .WIDTH (WIDTH)
    ) u_seg_select (
        .carry      (carry_q),
        .s1_seg     (s1_q[cnt_q]),
        .s2_seg     (s2_q[cnt_q]),
        .c_out1_bit (c_out1_q[cnt_q]),
        .c_out2_bit (c_out2_q[cnt_q]),
        .sum_seg    (seg_sum),
        .carry_next (seg_carry),
        .err_bit    (seg_err)
    );

    // Datapath: candidates captured on acceptance, one segment resolved per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q     <= '0;
            s2_q     <= '0;
            c_out1_q <= '0;
            c_out2_q <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            err_q    <= 1'b0;
        end else if (accept) begin
            s1_q     <= s1;
            s2_q     <= s2;
            c_out1_q <= c_out1;
            c_out2_q <= c_out2;
            cnt_q    <= '0;
            carry_q  <= c_in;
            err_q    <= 1'b0;
        end else if (state_q == StResolve) begin
            sum_q[cnt_q] <= seg_sum;
            carry_q      <= seg_carry;
            err_q        <= err_q | seg_err;
            // Saturate on the last segment so the index stays in range.
            if (cnt_q != LastSeg) begin
                cnt_q <= cnt_q + CntW'(1);
            end
        end
    end

    assign sum   = sum_q;
    assign c_out = carry_q;
    assign err   = err_q;

endmodule
